// File: rtl/ctrl_pkg.sv
// ctrl_pkg -- shared definitions for the multi-cycle controller.
//   ctrl_state_t : FSM state encoding (also exported on the debug state port)
//   OP_* / EXT_* : opcode and opcode-extension values decoded by the FSM
//   COND_*       : branch condition codes (IR[11:8] of a conditional branch)
//   HALT_WORD    : instruction word that stops the core
package ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH      = 4'd0,
      FETCH_WAIT = 4'd1,
      DECODE     = 4'd2,
      EXEC       = 4'd3,
      MEM_RD     = 4'd4,
      WB         = 4'd5,
      MEM_WR     = 4'd6,
      BRANCH     = 4'd7,
      HALT       = 4'd8
   } ctrl_state_t;

   localparam logic [3:0] OP_RTYPE = 4'h0;
   localparam logic [3:0] OP_MEM   = 4'h4;
   localparam logic [3:0] OP_BCOND = 4'hC;
   localparam logic [3:0] EXT_LOAD = 4'h0;
   localparam logic [3:0] EXT_STOR = 4'h4;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_LT = 4'hC;
   localparam logic [3:0] COND_GE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;

   localparam logic [15:0] HALT_WORD = 16'hFFFF;

endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval -- combinational branch condition evaluation.
//   cond   in  4  condition code
//   flag_z in  1  ALU zero flag
//   flag_n in  1  ALU negative flag
//   taken  out 1  branch is taken
// Unlisted condition codes are never taken.
module branch_cond_eval
   import ctrl_pkg::*;
(
   input  logic [3:0] cond,
   input  logic       flag_z,
   input  logic       flag_n,
   output logic       taken
);

   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_EQ: taken = flag_z;
         COND_NE: taken = ~flag_z;
         COND_LT: taken = flag_n;
         COND_GE: taken = ~flag_n;
         COND_AL: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm -- multi-cycle fetch/decode/execute controller.
//   clk, rst (sync, active-low), run (fetch permit, sampled in FETCH)
//   instruction : BRAM port-A output, latched internally when ir_load is high
//   flag_z/n    : ALU flags, looked at only in the BRANCH cycle
//   outputs     : ir_load, pc_enable, pc_load, r_enable, r_or_i, wb_sel,
//                 mem_addr_sel, mem_we, halted, state (debug)
// Optional feature macro: CTRL_BRANCH_EN (conditional branches). Without it
// opcode 1100 executes as a NOP and the flag inputs are ignored.
module multicycle_control_fsm
   import ctrl_pkg::*;
#(
   parameter int MEM_LATENCY    = 1,
   parameter int INSTR_WIDTH    = 16,
   parameter int WAIT_CNT_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   run,
   input  logic [INSTR_WIDTH-1:0] instruction,
   input  logic                   flag_z,
   input  logic                   flag_n,
   output logic                   ir_load,
   output logic                   pc_enable,
   output logic                   pc_load,
   output logic                   r_enable,
   output logic                   r_or_i,
   output logic                   wb_sel,
   output logic                   mem_addr_sel,
   output logic                   mem_we,
   output logic                   halted,
   output logic [3:0]             state
);

   localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LAST = WAIT_CNT_WIDTH'(MEM_LATENCY - 1);

   ctrl_state_t                state_reg, state_next;
   logic [WAIT_CNT_WIDTH-1:0]  wait_cnt_reg, wait_cnt_next;
   logic [INSTR_WIDTH-1:0]     ir_reg;
   logic                       wait_done;
   logic                       branch_taken;
   logic [3:0]                 opcode, opext;

   assign opcode    = ir_reg[15:12];
   assign opext     = ir_reg[7:4];
   assign wait_done = (wait_cnt_reg == WAIT_LAST);
   assign state     = state_reg;

`ifdef CTRL_BRANCH_EN
   branch_cond_eval u_cond (
      .cond   (ir_reg[11:8]),
      .flag_z (flag_z),
      .flag_n (flag_n),
      .taken  (branch_taken)
   );
`else
   logic unused_flags;
   assign unused_flags = flag_z ^ flag_n;
   assign branch_taken = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg    <= FETCH;
         wait_cnt_reg <= '0;
         ir_reg       <= '0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
         if (ir_load)
            ir_reg <= instruction;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         FETCH:      if (run) state_next = FETCH_WAIT;
         FETCH_WAIT: if (wait_done) state_next = DECODE;
         DECODE: begin
            if (&ir_reg) begin
               state_next = HALT;
            end else begin
               case (opcode)
                  OP_RTYPE: state_next = EXEC;
                  OP_MEM: begin
                     if (opext == EXT_LOAD)      state_next = MEM_RD;
                     else if (opext == EXT_STOR) state_next = MEM_WR;
                     else                        state_next = EXEC;
                  end
`ifdef CTRL_BRANCH_EN
                  OP_BCOND: state_next = BRANCH;
`endif
                  default:  state_next = EXEC;
               endcase
            end
         end
         MEM_RD:  if (wait_done) state_next = WB;
         EXEC, WB, MEM_WR, BRANCH: state_next = FETCH;
         HALT:    state_next = HALT;
         default: state_next = FETCH;
      endcase

      // Counter restarts on every state change and saturates at the last
      // wait count, so both wait states see exactly MEM_LATENCY cycles.
      if (state_next != state_reg)
         wait_cnt_next = '0;
      else if (wait_done)
         wait_cnt_next = wait_cnt_reg;
      else
         wait_cnt_next = wait_cnt_reg + 1'b1;
   end

   // Moore output decode; everything is forced low while rst is asserted so
   // an in-flight store cannot strobe on the reset cycle.
   always_comb begin
      ir_load      = 1'b0;
      pc_enable    = 1'b0;
      pc_load      = 1'b0;
      r_enable     = 1'b0;
      r_or_i       = 1'b0;
      wb_sel       = 1'b0;
      mem_addr_sel = 1'b0;
      mem_we       = 1'b0;
      halted       = 1'b0;
      if (rst) begin
         case (state_reg)
            FETCH_WAIT: ir_load = wait_done;
            EXEC: begin
               pc_enable = 1'b1;
               // OP_MEM (bad opext) and OP_BCOND (branches disabled) reach
               // EXEC only as NOPs: no register write.
               if (opcode == OP_RTYPE) begin
                  r_enable = 1'b1;
               end else if (opcode != OP_MEM && opcode != OP_BCOND) begin
                  r_enable = 1'b1;
                  r_or_i   = 1'b1;
               end
            end
            MEM_RD: mem_addr_sel = 1'b1;
            WB: begin
               r_enable     = 1'b1;
               wb_sel       = 1'b1;
               mem_addr_sel = 1'b1;
               pc_enable    = 1'b1;
            end
            MEM_WR: begin
               mem_addr_sel = 1'b1;
               mem_we       = 1'b1;
               pc_enable    = 1'b1;
            end
            BRANCH: begin
               pc_load   = branch_taken;
               pc_enable = ~branch_taken;
            end
            HALT:    halted = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Testbench for multicycle_control_fsm: two instances (MEM_LATENCY 1 and 3)
// run the same instruction side by side; each cycle's outputs are compared
// with a per-cycle timeline derived from the instruction class.
module tb_multicycle_control_fsm;
   import ctrl_pkg::*;

   localparam logic [8:0] B_IRL = 9'h001;
   localparam logic [8:0] B_PCE = 9'h002;
   localparam logic [8:0] B_PCL = 9'h004;
   localparam logic [8:0] B_REN = 9'h008;
   localparam logic [8:0] B_RI  = 9'h010;
   localparam logic [8:0] B_WB  = 9'h020;
   localparam logic [8:0] B_MAS = 9'h040;
   localparam logic [8:0] B_WE  = 9'h080;
   localparam logic [8:0] B_HLT = 9'h100;
   localparam int HALT_CYCLES = 10;

   logic        clk = 1'b0;
   logic        rst, run1, run3, flag_z, flag_n;
   logic [15:0] instruction;
   wire  [8:0]  out1, out3;
   wire  [3:0]  state1, state3;
   int          tests_run = 0;
   int          tests_failed = 0;

   always #5 clk = ~clk;

   multicycle_control_fsm #(.MEM_LATENCY(1), .INSTR_WIDTH(16), .WAIT_CNT_WIDTH(4)) dut1 (
      .clk(clk), .rst(rst), .run(run1), .instruction(instruction),
      .flag_z(flag_z), .flag_n(flag_n),
      .ir_load(out1[0]), .pc_enable(out1[1]), .pc_load(out1[2]), .r_enable(out1[3]),
      .r_or_i(out1[4]), .wb_sel(out1[5]), .mem_addr_sel(out1[6]), .mem_we(out1[7]),
      .halted(out1[8]), .state(state1));

   multicycle_control_fsm #(.MEM_LATENCY(3), .INSTR_WIDTH(16), .WAIT_CNT_WIDTH(4)) dut3 (
      .clk(clk), .rst(rst), .run(run3), .instruction(instruction),
      .flag_z(flag_z), .flag_n(flag_n),
      .ir_load(out3[0]), .pc_enable(out3[1]), .pc_load(out3[2]), .r_enable(out3[3]),
      .r_or_i(out3[4]), .wb_sel(out3[5]), .mem_addr_sel(out3[6]), .mem_we(out3[7]),
      .halted(out3[8]), .state(state3));

   // Cycles from the FETCH cycle up to (not including) the next FETCH.
   function automatic int trace_len(input logic [15:0] ir, input int lat);
      if (ir == HALT_WORD) return lat + 2 + HALT_CYCLES;
      if (ir[15:12] == 4'h4 && ir[7:4] == 4'h0) return 2 * lat + 3;
      return lat + 3;
   endfunction

   function automatic bit cond_met(input logic [3:0] c, input bit z, input bit n);
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'hC: return n;
         4'hD: return !n;
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Expected output word in cycle k (k = 0 is the FETCH cycle).
   function automatic logic [8:0] exp_word(input logic [15:0] ir, input int lat,
                                           input bit z, input bit n, input int k);
      logic [3:0] op, ext;
      int body;
      op   = ir[15:12];
      ext  = ir[7:4];
      body = k - lat - 2;
      if (k == 0) return '0;
      if (k <= lat) return (k == lat) ? B_IRL : 9'h000;
      if (k == lat + 1) return '0;
      if (ir == HALT_WORD) return B_HLT;
      if (op == 4'h0) return B_REN | B_PCE;
      if (op == 4'h4) begin
         if (ext == 4'h0) return (body < lat) ? B_MAS : (B_REN | B_WB | B_MAS | B_PCE);
         if (ext == 4'h4) return B_MAS | B_WE | B_PCE;
         return B_PCE;
      end
      if (op == 4'hC) begin
`ifdef CTRL_BRANCH_EN
         return cond_met(ir[11:8], z, n) ? B_PCL : B_PCE;
`else
         return B_PCE;
`endif
      end
      return B_REN | B_RI | B_PCE;
   endfunction

   // Runs one instruction through both instances; caller is at a negedge
   // with both in FETCH. Returns at a negedge.
   task automatic do_instr(input logic [15:0] ir, input bit z, input bit n, input string name);
      int len1, len3, maxl;
      bit is_halt;
      logic [3:0] end_state;
      logic [8:0] e;
      is_halt = (ir == HALT_WORD);
      len1 = trace_len(ir, 1);
      len3 = trace_len(ir, 3);
      maxl = (len1 > len3) ? len1 : len3;
      instruction = ir;
      flag_z = z;
      flag_n = n;
      for (int k = 0; k < maxl; k++) begin
         if (k == 0) begin
            run1 = 1'b1; run3 = 1'b1;
         end else if (is_halt) begin
            run1 = 1'($urandom_range(0, 1)); run3 = 1'($urandom_range(0, 1));
         end else begin
            run1 = 1'b0; run3 = 1'b0;
         end
         #1;
         if (k < len1) begin
            e = exp_word(ir, 1, z, n, k);
            tests_run++;
            if (out1 !== e) begin
               tests_failed++;
               $display("[TB] FAIL %s L1 cycle %0d outputs=%h expected=%h", name, k, out1, e);
            end
         end
         if (k < len3) begin
            e = exp_word(ir, 3, z, n, k);
            tests_run++;
            if (out3 !== e) begin
               tests_failed++;
               $display("[TB] FAIL %s L3 cycle %0d outputs=%h expected=%h", name, k, out3, e);
            end
         end
         @(negedge clk);
      end
      end_state = is_halt ? 4'(HALT) : 4'(FETCH);
      tests_run++;
      if (state1 !== end_state || state3 !== end_state) begin
         tests_failed++;
         $display("[TB] FAIL %s end_state L1=%0d L3=%0d expected=%0d", name, state1, state3, end_state);
      end
      $display("[TB] %s ir=%h z=%0d n=%0d cycles L1=%0d L3=%0d", name, ir, z, n, len1, len3);
   endtask

   task automatic test_reset();
      rst = 1'b0; run1 = 1'b1; run3 = 1'b1;
      instruction = 16'h0135; flag_z = 1'b0; flag_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      tests_run++;
      if (out1 !== 9'h000 || out3 !== 9'h000) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs L1=%h L3=%h expected=000", out1, out3);
      end
      tests_run++;
      if (state1 !== 4'(FETCH) || state3 !== 4'(FETCH)) begin
         tests_failed++;
         $display("[TB] FAIL reset_state L1=%0d L3=%0d expected=0", state1, state3);
      end
      @(negedge clk);
      rst = 1'b1;
      do_instr(16'h0135, 1'b0, 1'b0, "reset_release_rtype");
   endtask

   task automatic test_directed();
      do_instr(16'h0135, 1'b1, 1'b0, "rtype");
      do_instr(16'h2A57, 1'b0, 1'b1, "itype");
      do_instr(16'h4302, 1'b0, 1'b0, "load");
      do_instr(16'h4241, 1'b1, 1'b1, "stor");
      do_instr(16'h4311, 1'b0, 1'b0, "mem_nop");
      do_instr(16'hC012, 1'b1, 1'b0, "beq_taken");
      do_instr(16'hC012, 1'b0, 1'b0, "beq_not_taken");
      do_instr(16'hC533, 1'b1, 1'b1, "cond0101");
      do_instr(16'hC144, 1'b0, 1'b0, "bne");
      do_instr(16'hCC55, 1'b0, 1'b1, "blt");
      do_instr(16'hCD66, 1'b0, 1'b1, "bge");
      do_instr(16'hCE77, 1'b0, 1'b0, "balways");
   endtask

   task automatic test_random();
      logic [15:0] ir;
      logic [31:0] r;
      logic [3:0]  op, ext;
      for (int i = 0; i < 30; i++) begin
         r = $urandom;
         case ($urandom_range(0, 3))
            0: op = 4'h0;
            1: op = 4'h4;
            2: op = 4'hC;
            default: op = r[31:28];
         endcase
         case ($urandom_range(0, 2))
            0: ext = 4'h0;
            1: ext = 4'h4;
            default: ext = r[27:24];
         endcase
         ir = {op, r[11:8], ext, r[3:0]};
         if (ir == HALT_WORD) ir = 16'hFFFE;
         do_instr(ir, r[16], r[17], "random");
      end
   endtask

   task automatic test_run_low();
      run1 = 1'b0; run3 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #1;
         tests_run++;
         if ({out1, out3} !== 18'h0 || state1 !== 4'(FETCH) || state3 !== 4'(FETCH)) begin
            tests_failed++;
            $display("[TB] FAIL run_low cycle %0d outputs=%h/%h states=%0d/%0d expected=0", i, out1, out3, state1, state3);
         end
         @(negedge clk);
      end
      $display("[TB] run_low 20 idle cycles");
   endtask

   task automatic test_reset_mid_stor();
      instruction = 16'h4241; flag_z = 1'b0; flag_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         run1 = (k == 0); run3 = (k == 0);
         @(negedge clk);
      end
      #1;
      tests_run++;
      if (state1 !== 4'(MEM_WR) || out1[7] !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL mid_stor_reach state=%0d mem_we=%b expected=6/1", state1, out1[7]);
      end
      rst = 1'b0;
      #1;
      tests_run++;
      if (out1 !== 9'h000 || out3 !== 9'h000) begin
         tests_failed++;
         $display("[TB] FAIL mid_stor_reset_outputs L1=%h L3=%h expected=000", out1, out3);
      end
      @(negedge clk);
      #1;
      tests_run++;
      if (state1 !== 4'(FETCH) || state3 !== 4'(FETCH)) begin
         tests_failed++;
         $display("[TB] FAIL mid_stor_state L1=%0d L3=%0d expected=0", state1, state3);
      end
      @(negedge clk);
      rst = 1'b1;
      $display("[TB] reset_mid_stor ir=4241");
      do_instr(16'h4302, 1'b0, 1'b0, "after_reset_load");
   endtask

   task automatic test_halt();
      do_instr(HALT_WORD, 1'b0, 1'b0, "halt");
      rst = 1'b0;
      @(negedge clk);
      #1;
      tests_run++;
      if (state1 !== 4'(FETCH) || state3 !== 4'(FETCH) || out1 !== 9'h000 || out3 !== 9'h000) begin
         tests_failed++;
         $display("[TB] FAIL halt_reset states=%0d/%0d outputs=%h/%h expected=0", state1, state3, out1, out3);
      end
      @(negedge clk);
      rst = 1'b1;
      do_instr(16'h0135, 1'b0, 1'b0, "after_halt_rtype");
   endtask

   initial begin
      rst = 1'b0; run1 = 1'b0; run3 = 1'b0;
      instruction = '0; flag_z = 1'b0; flag_n = 1'b0;
      @(negedge clk);
      test_reset();
      test_directed();
      test_random();
      test_run_low();
      test_reset_mid_stor();
      test_halt();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
